// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its front-end arbiter.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter: round-robin or fixed priority (A wins), remembering the last grant.
module rr_arbiter2
  import instr_register_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    enable,
  input  logic    req_a,
  input  logic    req_b,
  output logic    grant_a,
  output logic    grant_b,
  output req_id_t grant_id
);

  req_id_t last_grant;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (enable) begin
      if (req_a && req_b) begin
        // Contention: B only wins in round-robin mode right after A was served.
        if (RR_EN && (last_grant == REQ_A)) grant_b = 1'b1;
        else                                grant_a = 1'b1;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  assign grant_id = grant_b ? REQ_B : REQ_A;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  last_grant <= REQ_B;
    else if (grant_a | grant_b) last_grant <= grant_id;
  end

endmodule

// File: rtl/instr_register_arbiter.sv
// Front end of the 32-entry instruction register: write-port arbitration,
// circular write/read pointers, occupancy tracking and one-cycle read-back.
module instr_register_arbiter
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  opcode_t                a_opcode,
  input  operand_t               a_operand_a,
  input  operand_t               a_operand_b,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  opcode_t                b_opcode,
  input  operand_t               b_operand_a,
  input  operand_t               b_operand_b,
  input  logic                   rd_req,
  output logic                   rd_ready,
  output logic                   rsp_valid,
  output instruction_t           rsp_word,
  output logic                   rsp_src,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   load_en,
  output address_t               write_pointer,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               read_pointer,
  input  instruction_t           instruction_word
);

  localparam int CW = $clog2(DEPTH) + 1;

  address_t         wr_ptr;
  address_t         rd_ptr;
  logic [DEPTH-1:0] src_tag;
  logic             grant_a;
  logic             grant_b;
  req_id_t          grant_id;
  logic             rd_fire;
  logic             vld_p1;
  instruction_t     word_p1;
  req_id_t          src_p1;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Holding the arbiter disabled during reset keeps both readies and load_en low.
  rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (!full && !reset),
    .req_a    (a_valid),
    .req_b    (b_valid),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .grant_id (grant_id)
  );

  assign a_ready       = grant_a;
  assign b_ready       = grant_b;
  assign load_en       = grant_a | grant_b;
  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  assign rd_ready      = !empty;
  assign rd_fire       = rd_req && !empty;

  always_comb begin
    opcode    = ZERO;
    operand_a = '0;
    operand_b = '0;
    if (grant_a) begin
      opcode    = a_opcode;
      operand_a = a_operand_a;
      operand_b = a_operand_b;
    end else if (grant_b) begin
      opcode    = b_opcode;
      operand_a = b_operand_a;
      operand_b = b_operand_b;
    end
  end

  // Stage p0 -> p1: pointer/occupancy update and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      src_tag <= '0;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      src_p1  <= REQ_A;
    end else begin
      vld_p1 <= rd_fire;
      if (load_en) begin
        src_tag[wr_ptr] <= grant_id;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        word_p1 <= instruction_word;
        src_p1  <= src_tag[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({load_en, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_word  = word_p1;
  assign rsp_src   = src_p1;

endmodule

// File: tb/tb_instr_register_arbiter.sv
// Bench for instr_register_arbiter: vector table, directed corner cases and a randomized queue model.
module tb_instr_register_arbiter;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         a_valid, b_valid, rd_req;
  opcode_t      a_opcode, b_opcode;
  operand_t     a_operand_a, a_operand_b, b_operand_a, b_operand_b;

  logic         a_ready, b_ready, rd_ready, rsp_valid, rsp_src, full, empty, load_en;
  instruction_t rsp_word, instruction_word;
  logic [5:0]   count;
  address_t     write_pointer, read_pointer;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;

  logic         fp_a_ready, fp_b_ready, fp_rd_ready, fp_rsp_valid, fp_rsp_src;
  logic         fp_full, fp_empty, fp_load_en;
  instruction_t fp_rsp_word, fp_word;
  logic [5:0]   fp_count;
  address_t     fp_write_pointer, fp_read_pointer;
  opcode_t      fp_opcode;
  operand_t     fp_operand_a, fp_operand_b;

  assign fp_word = '0;

  always #5 clk = ~clk;

  instr_register_arbiter #(.DEPTH(32), .RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_operand_a(a_operand_a), .a_operand_b(a_operand_b),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode),
    .b_operand_a(b_operand_a), .b_operand_b(b_operand_b),
    .rd_req(rd_req), .rd_ready(rd_ready), .rsp_valid(rsp_valid),
    .rsp_word(rsp_word), .rsp_src(rsp_src), .count(count),
    .full(full), .empty(empty), .load_en(load_en),
    .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .instruction_word(instruction_word)
  );

  instr_register_arbiter #(.DEPTH(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(fp_a_ready), .a_opcode(a_opcode),
    .a_operand_a(a_operand_a), .a_operand_b(a_operand_b),
    .b_valid(b_valid), .b_ready(fp_b_ready), .b_opcode(b_opcode),
    .b_operand_a(b_operand_a), .b_operand_b(b_operand_b),
    .rd_req(rd_req), .rd_ready(fp_rd_ready), .rsp_valid(fp_rsp_valid),
    .rsp_word(fp_rsp_word), .rsp_src(fp_rsp_src), .count(fp_count),
    .full(fp_full), .empty(fp_empty), .load_en(fp_load_en),
    .write_pointer(fp_write_pointer), .opcode(fp_opcode),
    .operand_a(fp_operand_a), .operand_b(fp_operand_b),
    .read_pointer(fp_read_pointer), .instruction_word(fp_word)
  );

  function automatic result_t alu(opcode_t o, operand_t x, operand_t y);
    result_t rx, ry;
    rx = result_t'(x);
    ry = result_t'(y);
    case (o)
      PASSA:   return rx;
      PASSB:   return ry;
      ADD:     return rx + ry;
      SUB:     return rx - ry;
      MULT:    return rx * ry;
      DIV:     return (ry == 0) ? result_t'(0) : rx / ry;
      MOD:     return (ry == 0) ? result_t'(0) : rx % ry;
      default: return result_t'(0);
    endcase
  endfunction

  // Instruction register: captures on load_en, combinational read.
  instruction_t regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk)
    if (load_en)
      regs[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                               rezultat: alu(opcode, operand_a, operand_b)};
  assign instruction_word = regs[read_pointer];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic bv, input opcode_t aop, input operand_t aa,
                       input operand_t ab, input opcode_t bop, input operand_t ba,
                       input operand_t bb, input logic rd);
    a_valid = av; a_opcode = aop; a_operand_a = aa; a_operand_b = ab;
    b_valid = bv; b_opcode = bop; b_operand_a = ba; b_operand_b = bb;
    rd_req  = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, ZERO, 0, 0, ZERO, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic rst; logic av; logic bv; opcode_t opc; int opa; int opb; logic rd;
    logic ear; logic ebr; logic efa; logic efb; int ewp; int ecnt;
    logic ersp; opcode_t eopc; longint eres; logic esrc;
  } vec_t;

  vec_t vt [19];

  typedef struct {
    opcode_t opc; operand_t a; operand_t b; logic src;
  } ent_t;

  ent_t    q[$];
  ent_t    exp_e;
  logic    last_b, ga, gb, fire, m_full, m_empty;
  int      wr_n, rd_n;
  logic    av, bv, rd, a_hold, b_hold;
  opcode_t aop, bop;
  operand_t aa, ab, ba, bb;
  int      wp, rp;

  initial begin
    //           rst av bv opc  opa opb rd  ar br fa fb wp cnt rsp eopc  eres src
    vt[0]  = '{1, 1, 0, ADD,  5, 3, 0,  1, 0, 1, 0, 0, 1,  0, ZERO, 0,   0};
    vt[1]  = '{0, 1, 0, SUB,  7, 2, 0,  1, 0, 1, 0, 1, 2,  0, ZERO, 0,   0};
    vt[2]  = '{0, 1, 0, MULT, 4, 4, 0,  1, 0, 1, 0, 2, 3,  0, ZERO, 0,   0};
    vt[3]  = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 2,  1, ADD,  8,   0};
    vt[4]  = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 1,  1, SUB,  5,   0};
    vt[5]  = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 0,  1, MULT, 16,  0};
    vt[6]  = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 0,  0, ZERO, 0,   0};
    vt[7]  = '{1, 1, 1, ADD,  0, 1, 0,  1, 0, 1, 0, 0, 1,  0, ZERO, 0,   0};
    vt[8]  = '{0, 1, 1, ADD,  1, 1, 0,  0, 1, 1, 0, 1, 2,  0, ZERO, 0,   0};
    vt[9]  = '{0, 1, 1, ADD,  2, 1, 0,  1, 0, 1, 0, 2, 3,  0, ZERO, 0,   0};
    vt[10] = '{0, 1, 1, ADD,  3, 1, 0,  0, 1, 1, 0, 3, 4,  0, ZERO, 0,   0};
    vt[11] = '{0, 1, 1, ADD,  4, 1, 0,  1, 0, 1, 0, 4, 5,  0, ZERO, 0,   0};
    vt[12] = '{0, 1, 1, ADD,  5, 1, 0,  0, 1, 1, 0, 5, 6,  0, ZERO, 0,   0};
    vt[13] = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 5,  1, ADD,  1,   0};
    vt[14] = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 4,  1, PASSB, 101, 1};
    vt[15] = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 3,  1, ADD,  3,   0};
    vt[16] = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 2,  1, PASSB, 101, 1};
    vt[17] = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 1,  1, ADD,  5,   0};
    vt[18] = '{0, 0, 0, ZERO, 0, 0, 1,  0, 0, 0, 0, 0, 0,  1, PASSB, 101, 1};

    // Reset state, with both requesters asserting valid.
    drive(1'b1, 1'b1, ADD, 1, 1, ADD, 2, 2, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst a_ready", a_ready, 0);
    chk("rst b_ready", b_ready, 0);
    chk("rst load_en", load_en, 0);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst rd_ready", rd_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst wp", write_pointer, 0);
    chk("rst rp", read_pointer, 0);
    idle();
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      if (vt[i].rst) do_reset();
      drive(vt[i].av, vt[i].bv, vt[i].opc, vt[i].opa, vt[i].opb,
            PASSB, vt[i].opa + 100, vt[i].opb + 100, vt[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d a_ready", i), a_ready, vt[i].ear);
      chk($sformatf("v%0d b_ready", i), b_ready, vt[i].ebr);
      chk($sformatf("v%0d fp_a_ready", i), fp_a_ready, vt[i].efa);
      chk($sformatf("v%0d fp_b_ready", i), fp_b_ready, vt[i].efb);
      chk($sformatf("v%0d load_en", i), load_en, vt[i].ear | vt[i].ebr);
      if (vt[i].ear | vt[i].ebr) chk($sformatf("v%0d wp", i), write_pointer, vt[i].ewp);
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), count, vt[i].ecnt);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, vt[i].ersp);
      if (vt[i].ersp) begin
        chk($sformatf("v%0d rsp_opc", i), rsp_word.opc, vt[i].eopc);
        chk($sformatf("v%0d rsp_res", i), rsp_word.rezultat, vt[i].eres);
        chk($sformatf("v%0d rsp_src", i), rsp_src, vt[i].esrc);
      end
    end
    idle();

    // Full: a same-cycle read does not let a write through.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, ADD, i, 0, ZERO, 0, 0, 1'b0);
      @(posedge clk); #1;
    end
    chk("fill count", count, 32);
    chk("fill full", full, 1);
    chk("fill empty", empty, 0);
    drive(1'b1, 1'b1, ADD, 99, 0, PASSB, 1, 1, 1'b0);
    @(negedge clk);
    chk("full a_ready", a_ready, 0);
    chk("full b_ready", b_ready, 0);
    chk("full load_en", load_en, 0);
    @(posedge clk); #1;
    chk("full hold count", count, 32);
    drive(1'b1, 1'b0, ADD, 99, 0, ZERO, 0, 0, 1'b1);
    @(negedge clk);
    chk("full rd a_ready", a_ready, 0);
    @(posedge clk); #1;
    chk("full rd count", count, 31);
    chk("full rd rsp_valid", rsp_valid, 1);
    chk("full rd rsp op_a", rsp_word.op_a, 0);
    drive(1'b1, 1'b0, ADD, 99, 0, ZERO, 0, 0, 1'b0);
    @(negedge clk);
    chk("refill a_ready", a_ready, 1);
    chk("refill wp wrap", write_pointer, 0);
    @(posedge clk); #1;
    chk("refill count", count, 32);
    chk("refill full", full, 1);

    // Randomized traffic against a queue model.
    do_reset();
    q.delete();
    last_b = 1'b1; wr_n = 0; rd_n = 0;
    a_hold = 1'b0; b_hold = 1'b0;
    av = 0; bv = 0; aop = ZERO; bop = ZERO; aa = 0; ab = 0; ba = 0; bb = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 150)      begin wp = 80; rp = 20; end
      else if (c < 300) begin wp = 20; rp = 80; end
      else              begin wp = 50; rp = 50; end
      if (!a_hold) begin
        av  = ($urandom_range(0, 99) < wp);
        aop = opcode_t'($urandom_range(0, 7));
        aa  = operand_t'($urandom_range(0, 2000)) - 1000;
        ab  = operand_t'($urandom_range(0, 2000)) - 1000;
      end
      if (!b_hold) begin
        bv  = ($urandom_range(0, 99) < wp);
        bop = opcode_t'($urandom_range(0, 7));
        ba  = operand_t'($urandom_range(0, 2000)) - 1000;
        bb  = operand_t'($urandom_range(0, 2000)) - 1000;
      end
      rd = ($urandom_range(0, 99) < rp);
      drive(av, bv, aop, aa, ab, bop, ba, bb, rd);
      @(negedge clk);
      m_full  = (q.size() == 32);
      m_empty = (q.size() == 0);
      ga = 1'b0; gb = 1'b0;
      if (!m_full) begin
        if (av && bv) begin
          if (last_b) ga = 1'b1; else gb = 1'b1;
        end else begin
          ga = av; gb = bv;
        end
      end
      chk($sformatf("r%0d a_ready", c), a_ready, ga);
      chk($sformatf("r%0d b_ready", c), b_ready, gb);
      chk($sformatf("r%0d load_en", c), load_en, ga | gb);
      if (ga | gb) chk($sformatf("r%0d wp", c), write_pointer, wr_n % 32);
      chk($sformatf("r%0d rp", c), read_pointer, rd_n % 32);
      chk($sformatf("r%0d count", c), count, q.size());
      chk($sformatf("r%0d full", c), full, m_full);
      chk($sformatf("r%0d empty", c), empty, m_empty);
      chk($sformatf("r%0d rd_ready", c), rd_ready, !m_empty);
      fire = rd && !m_empty;
      if (fire) begin
        exp_e = q.pop_front();
        rd_n++;
      end
      if (ga) q.push_back('{opc: aop, a: aa, b: ab, src: 1'b0});
      if (gb) q.push_back('{opc: bop, a: ba, b: bb, src: 1'b1});
      if (ga | gb) begin
        wr_n++;
        last_b = gb;
      end
      @(posedge clk); #1;
      chk($sformatf("r%0d rsp_valid", c), rsp_valid, fire);
      if (fire) begin
        chk($sformatf("r%0d rsp_opc", c), rsp_word.opc, exp_e.opc);
        chk($sformatf("r%0d rsp_a", c), rsp_word.op_a, exp_e.a);
        chk($sformatf("r%0d rsp_b", c), rsp_word.op_b, exp_e.b);
        chk($sformatf("r%0d rsp_res", c), rsp_word.rezultat, alu(exp_e.opc, exp_e.a, exp_e.b));
        chk($sformatf("r%0d rsp_src", c), rsp_src, exp_e.src);
      end
      a_hold = av && !ga;
      b_hold = bv && !gb;
    end
    idle();

    // Reset in the middle of traffic with a response on the output.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, ADD, i, 1, ZERO, 0, 0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, ADD, 50, 1, ZERO, 0, 0, 1'b1);
    @(posedge clk); #1;
    chk("mid count", count, 10);
    chk("mid rsp_valid", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid rst rsp_valid", rsp_valid, 0);
    chk("mid rst count", count, 0);
    chk("mid rst empty", empty, 1);
    chk("mid rst a_ready", a_ready, 0);
    chk("mid rst load_en", load_en, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 1'b1, SUB, 9, 3, PASSA, 4, 4, 1'b0);
    @(negedge clk);
    chk("post a_ready", a_ready, 1);
    chk("post b_ready", b_ready, 0);
    chk("post wp", write_pointer, 0);
    @(posedge clk); #1;
    chk("post count", count, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
